// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
//   Types, constants and helpers shared by the 4-way round-robin arbiter and
//   its request-queue front end (rr_req_queue).
//   - NUM_CH / CH_W  : channel count and channel-index width (fixed at 4 / 2)
//   - ch_mask_t      : one bit per channel (req / grant vectors)
//   - ch_idx_t       : binary channel index
//   - onehot_to_idx  : one-hot mask to binary index (OR of set positions)
//   - is_onehot      : 1 when exactly one bit of the mask is set
// -----------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [NUM_CH-1:0] ch_mask_t;
  typedef logic [CH_W-1:0]   ch_idx_t;

  // Only meaningful for a one-hot mask; callers qualify it with is_onehot().
  function automatic ch_idx_t onehot_to_idx(input ch_mask_t mask);
    ch_idx_t idx;
    idx = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        idx = idx | ch_idx_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic bit is_onehot(input ch_mask_t mask);
    return (mask != {NUM_CH{1'b0}}) &&
           ((mask & (mask - ch_mask_t'(1'b1))) == {NUM_CH{1'b0}});
  endfunction

endpackage

// File: rtl/rr_chan_fifo.sv
// -----------------------------------------------------------------------------
// rr_chan_fifo
//   Single-clock synchronous FIFO with registered occupancy count. Push into a
//   full FIFO and pop from an empty FIFO are ignored, so full/empty always
//   refer to the occupancy before the current edge.
//   Ports:
//     clk, rst_an  clock, asynchronous active-low reset (empties the FIFO)
//     push, wdata  write request and payload
//     pop          read request (advances the head)
//     rdata        current head entry (valid while !empty)
//     full, empty  occupancy flags, decoded from the registered count
// -----------------------------------------------------------------------------
module rr_chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == DEPTH_C);
  assign empty  = (r_count == {CNT_W{1'b0}});
  assign rdata  = r_mem[r_rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/rr_req_queue.sv
// -----------------------------------------------------------------------------
// rr_req_queue
//   Front end for the 4-way round-robin arbiter. Buffers payloads from four
//   producer channels in per-channel FIFOs, presents "channel non-empty" as the
//   arbiter request vector, and on each legal one-hot grant pops that channel's
//   head onto a single registered output.
//   Ports:
//     clk, rst_an  clock, asynchronous active-low reset
//     in_valid     per-channel push request
//     in_ready     per-channel "FIFO not full" (registered occupancy only)
//     in_data      channel i payload at [i*DATA_W +: DATA_W]
//     req          to arbiter; req[i] = FIFO i non-empty
//     grant        from arbiter; one-hot or zero
//     out_valid    one-cycle pulse per pop
//     out_ch       channel index of the popped payload (held between pops)
//     out_data     popped payload (held between pops)
//     err          sticky protocol error
//   Build option RRQ_PROTOCOL_CHECK_EN: when defined, err latches on any
//   non-one-hot non-zero grant or a grant to an empty channel, and clears only
//   on reset. When undefined, err is tied low and no check logic exists.
// -----------------------------------------------------------------------------
module rr_req_queue
  import rr_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_an,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        grant,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     err
);

  ch_mask_t          w_full;
  ch_mask_t          w_empty;
  ch_mask_t          w_push;
  ch_mask_t          w_pop;
  logic              w_pop_any;
  ch_idx_t           w_grant_idx;
  logic [DATA_W-1:0] w_rdata [NUM_CH];

  logic              r_out_valid;
  ch_idx_t           r_out_ch;
  logic [DATA_W-1:0] r_out_data;

  // A full FIFO rejects a push even if it pops in the same cycle.
  assign w_push   = in_valid & ~w_full;
  assign in_ready = ~w_full;
  assign req      = ~w_empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rr_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_an (rst_an),
      .push   (w_push[g]),
      .wdata  (in_data[g*DATA_W +: DATA_W]),
      .pop    (w_pop[g]),
      .rdata  (w_rdata[g]),
      .full   (w_full[g]),
      .empty  (w_empty[g])
    );
  end

  // Grant decode: only a one-hot grant onto a non-empty channel pops.
  always_comb begin
    w_grant_idx = onehot_to_idx(grant);
    w_pop       = {NUM_CH{1'b0}};
    w_pop_any   = 1'b0;
    if (is_onehot(grant) && ((grant & ~w_empty) != {NUM_CH{1'b0}})) begin
      w_pop     = grant;
      w_pop_any = 1'b1;
    end else begin
      w_pop     = {NUM_CH{1'b0}};
      w_pop_any = 1'b0;
    end
  end

  // Output register: pulse valid on a pop, hold channel/data otherwise.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= {CH_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
    end else if (w_pop_any) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= w_grant_idx;
      r_out_data  <= w_rdata[w_grant_idx];
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

`ifdef RRQ_PROTOCOL_CHECK_EN
  logic w_proto_bad;
  logic r_err;

  // Protocol violation: multi-hot grant, or any grant bit on an empty channel.
  always_comb begin
    w_proto_bad = 1'b0;
    if (grant != {NUM_CH{1'b0}}) begin
      w_proto_bad = !is_onehot(grant) || ((grant & w_empty) != {NUM_CH{1'b0}});
    end else begin
      w_proto_bad = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_proto_bad;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
module tb_rr_req_queue;

`ifdef RRQ_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst_an;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  tb_grant;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;
  logic        err;

  // behavioural round-robin arbiter: registered grant, idle cycle after each grant
  logic        use_arb;
  logic [3:0]  arb_grant;
  logic [3:0]  arb_next;
  logic [1:0]  arb_ptr;
  logic [1:0]  arb_next_idx;

  int n_tests;
  int n_fail;

  // reference model: per-channel circular buffers plus expected-output scoreboard
  logic [7:0] m_mem [4][4];
  int         m_head [4];
  int         m_cnt  [4];
  logic [9:0] sb [$];

  assign grant = use_arb ? arb_grant : tb_grant;

  rr_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_an    (rst_an),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    arb_next     = 4'b0000;
    arb_next_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[(int'(arb_ptr) + k) % 4]) begin
        arb_next     = 4'b0001 << ((int'(arb_ptr) + k) % 4);
        arb_next_idx = 2'((int'(arb_ptr) + k) % 4);
      end
    end
  end

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      arb_grant <= 4'b0000;
      arb_ptr   <= 2'd0;
    end else if (!use_arb || arb_grant != 4'b0000) begin
      arb_grant <= 4'b0000;
    end else if (arb_next != 4'b0000) begin
      arb_grant <= arb_next;
      arb_ptr   <= arb_next_idx + 2'd1;
    end
  end

  // scoreboard consumer: every out_valid pulse must match the oldest expected pop
  always @(negedge clk) begin
    if (rst_an && out_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got ch=%0d data=%h, required no output", out_ch, out_data);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({out_ch, out_data} !== e) begin
          n_fail++;
          $display("FAIL sb_data: got ch=%0d data=%h, required ch=%0d data=%h",
                   out_ch, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_head[i] = 0;
      m_cnt[i]  = 0;
    end
    sb.delete();
  endtask

  // apply the effect of the next clock edge, using pre-edge occupancy
  task automatic model_edge(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
    int pre [4];
    int gi;
    gi = 0;
    for (int i = 0; i < 4; i++) pre[i] = m_cnt[i];
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    if ($onehot(g) && pre[gi] != 0) begin
      sb.push_back({2'(gi), m_mem[gi][m_head[gi]]});
      m_head[gi] = (m_head[gi] + 1) % 4;
      m_cnt[gi]  = m_cnt[gi] - 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i] && pre[i] < 4) begin
        m_mem[i][(m_head[i] + m_cnt[i]) % 4] = d[i*8 +: 8];
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  // drive one edge's worth of stimulus from a negedge, return at the next negedge
  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
    model_edge(v, d, g);
    in_valid = v;
    in_data  = d;
    tb_grant = g;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    tb_grant = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_an   = 1'b0;
    in_valid = 4'hF;
    in_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'hF || req !== 4'h0 || out_valid !== 1'b0 || err !== 1'b0 ||
          out_ch !== 2'd0 || out_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%h req=%h ov=%b err=%b ch=%0d data=%h, required F 0 0 0 0 00",
                 in_ready, req, out_valid, err, out_ch, out_data);
      end
    end
    in_valid = 4'h0;
    rst_an   = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req !== 4'h0 || in_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release: got req=%h rdy=%h, required 0 F", req, in_ready);
    end
  endtask

  task automatic test_single();
    drive(4'b0100, 32'h00A5_0000, 4'b0000);
    n_tests++;
    if (req !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_req: got %b, required 0100", req);
    end
    drive(4'b0000, 32'h0, 4'b0100);
    n_tests++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hA5 || req !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_pop: got ov=%b ch=%0d data=%h req=%b, required 1 2 a5 0000",
               out_valid, out_ch, out_data, req);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) drive(4'b0001, {24'h0, 8'h10 + 8'(i)}, 4'b0000);
    n_tests++;
    if (in_ready[0] !== 1'b0 || req[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready: got rdy0=%b req0=%b, required 0 1", in_ready[0], req[0]);
    end
    drive(4'b0001, 32'h0000_0099, 4'b0001);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h10 || in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject: got ov=%b data=%h rdy0=%b, required 1 10 1",
               out_valid, out_data, in_ready[0]);
    end
    for (int k = 1; k < 4; k++) begin
      drive(4'b0000, 32'h0, 4'b0001);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k)) begin
        n_fail++;
        $display("FAIL full_order: got ov=%b data=%h, required 1 %h", out_valid, out_data, 8'h10 + 8'(k));
      end
    end
    n_tests++;
    if (req[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: got req0=%b, required 0", req[0]);
    end
  endtask

  task automatic test_wrap_simul();
    drive(4'b0010, {16'h0, 8'h40, 8'h0}, 4'b0000);
    drive(4'b0010, {16'h0, 8'h41, 8'h0}, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, {16'h0, 8'h42 + 8'(k), 8'h0}, 4'b0010);
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h40 + 8'(k) ||
          req[1] !== 1'b1 || in_ready[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_simul: got ov=%b ch=%0d data=%h req1=%b rdy1=%b, required 1 1 %h 1 1",
                 out_valid, out_ch, out_data, req[1], in_ready[1], 8'h40 + 8'(k));
      end
    end
    drive(4'b0000, 32'h0, 4'b0010);
    drive(4'b0000, 32'h0, 4'b0010);
    n_tests++;
    if (out_data !== 8'h4B || req[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain: got data=%h req1=%b, required 4b 0", out_data, req[1]);
    end
  endtask

  task automatic test_illegal_grant();
    drive(4'b0011, 32'h0000_5566, 4'b0000);
    drive(4'b0000, 32'h0, 4'b0011);
    n_tests++;
    if (out_valid !== 1'b0 || req !== 4'b0011 || err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL illegal_multi: got ov=%b req=%b err=%b, required 0 0011 %b",
               out_valid, req, err, EXP_ERR);
    end
    drive(4'b0000, 32'h0, 4'b1000);
    n_tests++;
    if (out_valid !== 1'b0 || req !== 4'b0011 || err !== EXP_ERR) begin
      n_fail++;
      $display("FAIL illegal_empty: got ov=%b req=%b err=%b, required 0 0011 %b",
               out_valid, req, err, EXP_ERR);
    end
    drive(4'b0000, 32'h0, 4'b0001);
    drive(4'b0000, 32'h0, 4'b0010);
    n_tests++;
    if (req !== 4'b0000 || out_data !== 8'h55) begin
      n_fail++;
      $display("FAIL illegal_drain: got req=%b data=%h, required 0000 55", req, out_data);
    end
  endtask

  task automatic test_arbiter();
    int pulses;
    int last;
    // full round: 2 entries per channel
    drive(4'hF, 32'h8382_8180, 4'b0000);
    drive(4'hF, 32'h8786_8584, 4'b0000);
    use_arb = 1'b1;
    pulses = 0;
    last   = 0;
    for (int c = 1; c <= 40 && pulses < 8; c++) begin
      model_edge(4'h0, 32'h0, grant);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_tests++;
        if (out_ch !== 2'(pulses % 4)) begin
          n_fail++;
          $display("FAIL arb_order: pulse %0d got ch=%0d, required %0d", pulses, out_ch, pulses % 4);
        end
        if (pulses > 0) begin
          n_tests++;
          if (c - last != 2) begin
            n_fail++;
            $display("FAIL arb_spacing: got %0d cycles, required 2", c - last);
          end
        end
        last = c;
        pulses++;
      end
    end
    n_tests++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL arb_timeout: got %0d pulses, required 8", pulses);
    end
    use_arb = 1'b0;
    // reset in the middle of a second round
    drive(4'hF, 32'h9392_9190, 4'b0000);
    drive(4'hF, 32'h9796_9594, 4'b0000);
    use_arb = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 20 && pulses < 3; c++) begin
      model_edge(4'h0, 32'h0, grant);
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    #2;
    rst_an = 1'b0;
    #1;
    model_reset();
    use_arb = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || req !== 4'h0 || in_ready !== 4'hF || out_ch !== 2'd0 ||
        out_data !== 8'h00 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got ov=%b req=%h rdy=%h ch=%0d data=%h err=%b, required 0 0 F 0 00 0",
               out_valid, req, in_ready, out_ch, out_data, err);
    end
    @(negedge clk);
    rst_an = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || req !== 4'h0) begin
        n_fail++;
        $display("FAIL post_reset: got ov=%b req=%h, required 0 0", out_valid, req);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_an   = 1'b0;
    in_valid = 4'h0;
    in_data  = 32'h0;
    tb_grant = 4'h0;
    use_arb  = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_full();
    test_wrap_simul();
    test_illegal_grant();
    test_arbiter();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending outputs, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
